// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one MAC unit through clear / accumulate / capture
// for each job of operand pairs and hands the dot-product downstream on a
// valid/ready result port.
// Optional build macro MAC_SEQ_CTRL_PERF_EN adds the perf_stall output, which
// counts accumulate cycles spent waiting for operands in each job.
module mac_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 8,
  parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_a,
  output logic [DATA_WIDTH-1:0]   mac_b,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic [3*DATA_WIDTH-1:0] res_data,
  output logic [LEN_W-1:0]        res_len,
  output logic                    res_trunc,
  output logic                    res_valid,
  input  logic                    res_ready
`ifdef MAC_SEQ_CTRL_PERF_EN
  ,
  output logic [15:0]             perf_stall
`endif
);

  localparam int RES_W = 3 * DATA_WIDTH;

  typedef enum logic [1:0] {S_CLR, S_ACC, S_CAP, S_OUT} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [RES_W-1:0]   res_data_q, res_data_d;
  logic [LEN_W-1:0]   res_len_q, res_len_d;
  logic               res_trunc_q, res_trunc_d;
  logic               res_valid_q, res_valid_d;
  logic               last_beat;

  // A beat closes the job when flagged last or when it fills the MAX_LEN budget.
  assign last_beat = in_last || (cnt_q == LEN_W'(MAX_LEN - 1));

  // Interface decode straight from the state; operands pass through untouched.
  assign in_ready  = (state_q == S_ACC);
  assign mac_en    = (state_q == S_ACC) && in_valid;
  assign mac_clr   = (state_q == S_CLR) || (state_q == S_CAP);
  assign mac_a     = in_a;
  assign mac_b     = in_b;
  assign res_data  = res_data_q;
  assign res_len   = res_len_q;
  assign res_trunc = res_trunc_q;
  assign res_valid = res_valid_q;

  // Next-state and result-capture logic for the job sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_len_d   = res_len_q;
    res_trunc_d = res_trunc_q;
    res_valid_d = res_valid_q;
    case (state_q)
      S_CLR: begin
        cnt_d   = '0;
        state_d = S_ACC;
      end
      S_ACC: begin
        if (in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            res_trunc_d = !in_last;
            state_d     = S_CAP;
          end
        end
      end
      S_CAP: begin
        // MAC output is registered, so the final sum is visible one cycle after
        // the last enable; the MAC is cleared in this same cycle.
        res_data_d  = mac_cout;
        res_len_d   = cnt_q;
        res_valid_d = 1'b1;
        cnt_d       = '0;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_ACC;
        end
      end
      default: state_d = S_CLR;
    endcase
  end

  // Controller state and result registers; reset discards any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CLR;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_len_q   <= '0;
      res_trunc_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_len_q   <= res_len_d;
      res_trunc_q <= res_trunc_d;
      res_valid_q <= res_valid_d;
    end
  end

`ifdef MAC_SEQ_CTRL_PERF_EN
  logic [15:0] stall_q, stall_d;
  logic [15:0] perf_q, perf_d;

  assign perf_stall = perf_q;

  // Saturating count of starved accumulate cycles, snapshotted with the result.
  always_comb begin
    stall_d = stall_q;
    perf_d  = perf_q;
    case (state_q)
      S_CLR: stall_d = '0;
      S_ACC: if (!in_valid && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
      S_CAP: perf_d = stall_q;
      S_OUT: if (res_ready) stall_d = '0;
      default: stall_d = '0;
    endcase
  end

  // Stall counter and its held snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      perf_q  <= '0;
    end else begin
      stall_q <= stall_d;
      perf_q  <= perf_d;
    end
  end
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: behavioural MAC, table of directed jobs, hand-written
// corner sequences and a randomized run against a job-level scoreboard.
module tb_mac_seq_ctrl;

  localparam int DW = 8;
  localparam int ML = 8;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_a, in_b;
  logic          in_last, in_valid, in_ready;
  logic          mac_en, mac_clr;
  logic [DW-1:0] mac_a, mac_b;
  logic [23:0]   mac_cout;
  logic [23:0]   res_data;
  logic [LW-1:0] res_len;
  logic          res_trunc, res_valid, res_ready;
`ifdef MAC_SEQ_CTRL_PERF_EN
  logic [15:0]   perf_stall;
`endif

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int res_cnt = 0;
  bit rand_done;

  mac_seq_ctrl #(.DATA_WIDTH(DW), .MAX_LEN(ML), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_a(mac_a), .mac_b(mac_b), .mac_cout(mac_cout), .res_data(res_data),
    .res_len(res_len), .res_trunc(res_trunc), .res_valid(res_valid),
    .res_ready(res_ready)
`ifdef MAC_SEQ_CTRL_PERF_EN
    , .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural MAC: registered accumulator sharing rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mac_cout <= '0;
    else if (mac_clr) mac_cout <= '0;
    else if (mac_en)  mac_cout <= mac_cout + 24'(mac_a) * 24'(mac_b);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Job-level reference: sums products of accepted beats, closes a job on
  // last or on the MAX_LEN-th beat, and expects results in order.
  typedef struct packed { logic [23:0] d; logic [3:0] len; logic tr; } res_t;
  res_t        exp_q[$];
  res_t        got_r, held;
  logic [23:0] m_acc;
  int          m_cnt;
  bit          hold_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_acc = '0; m_cnt = 0; exp_q.delete(); hold_prev = 0;
    end else begin
      chk("en_clr_excl", {31'd0, mac_en && mac_clr}, 32'd0);
      if (hold_prev) begin
        chk("hold_valid", {31'd0, res_valid}, 32'd1);
        chk("hold_data", {8'd0, res_data}, {8'd0, held.d});
        chk("hold_len", {28'd0, res_len}, {28'd0, held.len});
        chk("hold_trunc", {31'd0, res_trunc}, {31'd0, held.tr});
      end
      if (mac_en) en_cnt++;
      if (in_valid && in_ready) begin
        m_acc = m_acc + 24'(in_a) * 24'(in_b);
        m_cnt++;
        if (in_last || m_cnt == ML) begin
          exp_q.push_back({m_acc, 4'(m_cnt), !in_last});
          m_acc = '0; m_cnt = 0;
        end
      end
      if (res_valid && res_ready) begin
        res_cnt++;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 32'd1, 32'd0);
        end else begin
          got_r = exp_q.pop_front();
          chk("sb_data", {8'd0, res_data}, {8'd0, got_r.d});
          chk("sb_len", {28'd0, res_len}, {28'd0, got_r.len});
          chk("sb_trunc", {31'd0, res_trunc}, {31'd0, got_r.tr});
        end
      end
      hold_prev = res_valid && !res_ready;
      held = {res_data, 4'(res_len), res_trunc};
    end
  end

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n;
    n = 0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    if (!in_ready) chk("beat_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!res_valid && lat < 40);
    if (!res_valid) chk("result_timeout", 32'd0, 32'd1);
  endtask

  typedef struct packed {
    logic [3:0]      n;
    logic [7:0][7:0] a;
    logic [7:0][7:0] b;
    logic            last;
    logic [23:0]     d;
    logic [3:0]      len;
    logic            tr;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, e0, nres, len, gap;
    rst_n = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; in_valid = 1'b0;
    res_ready = 1'b1; rand_done = 0;

    for (int i = 0; i < 6; i++) tbl[i] = '0;
    tbl[0].n = 3; tbl[0].last = 1; tbl[0].d = 24'd62; tbl[0].len = 3; tbl[0].tr = 0;
    tbl[0].a[0] = 3; tbl[0].b[0] = 4; tbl[0].a[1] = 5; tbl[0].b[1] = 6;
    tbl[0].a[2] = 2; tbl[0].b[2] = 10;
    tbl[1].n = 8; tbl[1].last = 0; tbl[1].d = 24'd8; tbl[1].len = 8; tbl[1].tr = 1;
    for (int k = 0; k < 8; k++) begin tbl[1].a[k] = 1; tbl[1].b[k] = 1; end
    tbl[2].n = 1; tbl[2].last = 1; tbl[2].d = 24'd1; tbl[2].len = 1; tbl[2].tr = 0;
    tbl[2].a[0] = 1; tbl[2].b[0] = 1;
    tbl[3].n = 1; tbl[3].last = 1; tbl[3].d = 24'd65025; tbl[3].len = 1; tbl[3].tr = 0;
    tbl[3].a[0] = 255; tbl[3].b[0] = 255;
    tbl[4].n = 8; tbl[4].last = 1; tbl[4].d = 24'd520200; tbl[4].len = 8; tbl[4].tr = 0;
    for (int k = 0; k < 8; k++) begin tbl[4].a[k] = 255; tbl[4].b[k] = 255; end
    tbl[5].n = 2; tbl[5].last = 1; tbl[5].d = 24'd51; tbl[5].len = 2; tbl[5].tr = 0;
    tbl[5].a[0] = 0; tbl[5].b[0] = 200; tbl[5].a[1] = 17; tbl[5].b[1] = 3;

    // reset and first cycles
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mac_clr", {31'd0, mac_clr}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", {8'd0, res_data}, 32'd0);
    chk("rst_res_len", {28'd0, res_len}, 32'd0);
    @(negedge clk);
    chk("acc_in_ready", {31'd0, in_ready}, 32'd1);
    chk("acc_mac_clr", {31'd0, mac_clr}, 32'd0);
    @(posedge clk); #1;

    // directed job table
    for (int i = 0; i < 6; i++) begin
      e0 = en_cnt;
      for (int k = 0; k < int'(tbl[i].n); k++)
        send_beat(tbl[i].a[k], tbl[i].b[k], tbl[i].last && (k == int'(tbl[i].n) - 1));
      wait_valid(lat);
      chk($sformatf("tbl%0d_latency", i), lat, 32'd2);
      chk($sformatf("tbl%0d_data", i), {8'd0, res_data}, {8'd0, tbl[i].d});
      chk($sformatf("tbl%0d_len", i), {28'd0, res_len}, {28'd0, tbl[i].len});
      chk($sformatf("tbl%0d_trunc", i), {31'd0, res_trunc}, {31'd0, tbl[i].tr});
      chk($sformatf("tbl%0d_en_cycles", i), en_cnt - e0, {28'd0, tbl[i].n});
      @(posedge clk); #1;
    end

    // nine beats of (1,1) held valid, ninth flagged last
    for (int k = 0; k < 9; k++) send_beat(8'd1, 8'd1, k == 8);
    repeat (4) @(posedge clk); #1;

    // back-to-back jobs with the result held off for 5 cycles
    res_ready = 1'b0;
    fork
      begin
        send_beat(8'd255, 8'd255, 1'b1);
        send_beat(8'd255, 8'd255, 1'b0);
        send_beat(8'd255, 8'd255, 1'b1);
      end
      begin
        wait_valid(lat);
        for (int c = 0; c < 5; c++) begin
          if (c > 0) @(negedge clk);
          chk("b2b_hold_data", {8'd0, res_data}, 32'd65025);
          chk("b2b_hold_valid", {31'd0, res_valid}, 32'd1);
          chk("b2b_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        @(posedge clk);
        wait_valid(lat);
        chk("b2b_second_data", {8'd0, res_data}, 32'd130050);
        chk("b2b_second_len", {28'd0, res_len}, 32'd2);
      end
    join
    @(posedge clk); #1;

    // reset in the middle of a job
    send_beat(8'd9, 8'd9, 1'b0);
    send_beat(8'd9, 8'd9, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_mac_clr", {31'd0, mac_clr}, 32'd1);
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    nres = res_cnt;
    send_beat(8'd7, 8'd7, 1'b1);
    wait_valid(lat);
    chk("midrst_data", {8'd0, res_data}, 32'd49);
    chk("midrst_len", {28'd0, res_len}, 32'd1);
    repeat (4) @(posedge clk); #1;
    chk("midrst_result_count", res_cnt - nres, 32'd1);

    // randomized jobs with gaps and downstream backpressure
    fork
      begin
        for (int j = 0; j < 40; j++) begin
          len = $urandom_range(1, 10);
          for (int k = 0; k < len; k++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            send_beat(8'($urandom), 8'($urandom), k == len - 1);
          end
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    res_ready = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk("sb_drained", exp_q.size(), 32'd0);

`ifdef MAC_SEQ_CTRL_PERF_EN
    // stall counter over a gapped three-beat job
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    send_beat(8'd1, 8'd2, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    send_beat(8'd3, 8'd4, 1'b0);
    send_beat(8'd5, 8'd6, 1'b1);
    wait_valid(lat);
    chk("perf_data", {8'd0, res_data}, 32'd44);
    chk("perf_stall", {16'd0, perf_stall}, 32'd4);
    @(posedge clk); #1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer that drives one MAC unit's En/Clr/Ain/Bin interface and collects its Cout.
- Upstream: valid/ready stream of operand pairs. Each job ends on a beat flagged last.
- Per job: clears the MAC, streams the pairs into it, captures the dot-product, and presents the result on a valid/ready output.
- Placement: sits between the operand FIFOs and each MAC in the array.

Parameters:
- DATA_WIDTH, 8, operand width; the result is 3*DATA_WIDTH.
- MAX_LEN, 8, maximum beats per job before forced termination.
- LEN_W, $clog2(MAX_LEN+1), width of the beat count.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_a  input  DATA_WIDTH  operand A.
- in_b  input  DATA_WIDTH  operand B.
- in_last  input  1  marks the final beat of a job.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  controller accepts a beat.
- mac_en  output  1  to MAC En.
- mac_clr  output  1  to MAC Clr.
- mac_a  output  DATA_WIDTH  to MAC Ain.
- mac_b  output  DATA_WIDTH  to MAC Bin.
- mac_cout  input  3*DATA_WIDTH  from MAC Cout (registered inside the MAC).
- res_data  output  3*DATA_WIDTH  captured dot-product.
- res_len  output  LEN_W  beats accumulated in this job.
- res_trunc  output  1  job was cut off at MAX_LEN without seeing in_last.
- res_valid  output  1  result valid.
- res_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (async, rst_n=0):
  - State=CLR, beat counter=0.
  - res_valid=0, res_data=0, res_len=0, res_trunc=0.
  - The MAC shares rst_n, so its accumulator is also 0.
- Output decoding:
  - in_ready = (state==ACC).
  - mac_en = (state==ACC) & in_valid.
  - mac_a/mac_b = in_a/in_b combinationally; they are don't-care when mac_en=0.
  - mac_clr = (state==CLR) | (state==CAP).
  - mac_en and mac_clr are never both 1.
- State CLR: one cycle with mac_clr=1; beat counter <= 0; next state ACC.
- State ACC, on each beat where in_valid=1:
  - The beat is accepted; the MAC accumulates a*b at this edge.
  - Beat counter increments.
  - If in_last=1 or counter==MAX_LEN-1: next state CAP. res_trunc <= (in_last==0).
  - in_valid=0 cycles stall with no state change.
- State CAP:
  - mac_cout now holds the final sum (one cycle after the last En).
  - res_data <= mac_cout, res_len <= counter, res_valid <= 1.
  - mac_clr=1 in the same cycle, so the MAC is zero from the next cycle.
  - Next state OUT.
- State OUT: in_ready=0 and mac_en=0. Hold res_data/res_len/res_trunc stable until res_valid & res_ready. At that edge res_valid <= 0 and next state ACC (MAC already cleared in CAP).
- Latency: last beat accepted at cycle t → res_valid=1 from cycle t+2. Minimum job period is beats+2 cycles when res_ready is held at 1.
- Width: the controller performs no arithmetic. Wrap of the 3*DATA_WIDTH accumulator is the MAC's behaviour and is passed through unchanged.
- A single-beat job (in_last on the first beat) gives res_len=1.
- Reset mid-job: the job is discarded with no partial result; the controller restarts in CLR.
- A res_ready held while res_valid=0 has no effect.

Optional Feature:
- Macro: MAC_SEQ_CTRL_PERF_EN.
- Defined: adds output perf_stall, 16 bits.
  - Counts ACC cycles with in_valid=0 in the current job; saturates at 16'hFFFF.
  - Zeroed in CLR and on entering ACC from OUT.
  - Latched alongside res_data in CAP and held through OUT.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset → in_ready=0 and mac_clr=1 in the first cycle. res_valid=0. in_ready=1 from the second cycle.
- Job (3,4),(5,6),(2,10,last) with in_valid held high:
  - Response: res_data=62, res_len=3, res_trunc=0, res_valid rising 2 cycles after the last beat.
  - mac_en high for exactly 3 cycles.
- 9 beats of (1,1) with no in_last, MAX_LEN=8:
  - First job: res_data=8, res_len=8, res_trunc=1.
  - The 9th beat, sent with last, starts a new job: res_data=1, res_len=1.
- Back-to-back jobs (255,255,last) then (255,255),(255,255,last), with res_ready held low 5 cycles:
  - res_data=65025 is held stable and in_ready=0 throughout the hold.
  - Second result=130050.
  - Checks that the MAC was cleared between jobs.
- Assert rst_n=0 after 2 beats of a job, then release and send (7,7,last) → the only result is 49 with res_len=1.
- With MAC_SEQ_CTRL_PERF_EN, job of 3 beats with in_valid gapped for 4 cycles → perf_stall=4 while res_valid=1.
